alu_cmd_sequencer: RTL and testbench

Command front-end for `simple_alu`.
- Accepts ALU commands (operands, opcode, tag) over a valid/ready interface and buffers them in a command FIFO.
- Issues at most one command per cycle to the ALU's registered inputs.
- Captures each ALU result exactly two cycles after issue into an in-order response queue with valid/ready output.
- A credit rule guarantees no result is dropped, because the ALU itself cannot stall.

---
 rtl/alu_cmd_sequencer.sv | 167 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command front-end for simple_alu. Commands {a, b, op, tag} are accepted
//   over a valid/ready handshake into a command FIFO, issued one per cycle
//   onto the ALU's registered inputs, and the ALU result is captured two
//   cycles after issue into an in-order response queue. Issue is gated by
//   a credit check so the non-stallable ALU can never produce a result that
//   has nowhere to go.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake
//   cmd_a, cmd_b, cmd_op : operands and opcode
//   cmd_tag              : user tag returned with the result
//   alu_a/alu_b/alu_opcode : registered drive into the ALU
//   alu_result           : registered result from the ALU
//   rsp_valid/rsp_ready  : response handshake
//   rsp_result, rsp_tag  : head of the response queue
//   rsp_illegal          : head command used opcode 3'b111
//   cmd_count            : command FIFO occupancy
//   busy                 : anything queued, in flight, or awaiting pop
module alu_cmd_sequencer #(
  parameter int DEPTH     = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [7:0]                 cmd_a,
  input  logic [7:0]                 cmd_b,
  input  logic [2:0]                 cmd_op,
  input  logic [TAG_W-1:0]           cmd_tag,
  output logic [7:0]                 alu_a,
  output logic [7:0]                 alu_b,
  output logic [2:0]                 alu_opcode,
  input  logic [15:0]                alu_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [15:0]                rsp_result,
  output logic [TAG_W-1:0]           rsp_tag,
  output logic                       rsp_illegal,
  output logic [$clog2(DEPTH+1)-1:0] cmd_count,
  output logic                       busy
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int RPW   = $clog2(RSP_DEPTH);
  localparam int RCW   = $clog2(RSP_DEPTH + 1);
  localparam int SW    = RCW + 2;
  localparam int CMD_W = 19 + TAG_W;
  localparam int RSP_W = 17 + TAG_W;

  logic [CMD_W-1:0] r_cmdMem [DEPTH];
  logic [PW-1:0]    r_cmdWrPtr;
  logic [PW-1:0]    r_cmdRdPtr;
  logic [CW-1:0]    r_cmdCount;

  logic             r_s1Valid;
  logic             r_s1Illegal;
  logic [TAG_W-1:0] r_s1Tag;
  logic             r_s2Valid;
  logic             r_s2Illegal;
  logic [TAG_W-1:0] r_s2Tag;

  logic [RSP_W-1:0] r_rspMem [RSP_DEPTH];
  logic [RPW-1:0]   r_rspWrPtr;
  logic [RPW-1:0]   r_rspRdPtr;
  logic [RCW-1:0]   r_rspCount;

  logic             w_cmdPush;
  logic             w_rspPop;
  logic             w_issue;
  logic [SW-1:0]    w_inUse;
  logic [CMD_W-1:0] w_cmdHead;

  // Response pointers wrap explicitly so RSP_DEPTH need not be a power of two.
  function automatic logic [RPW-1:0] rspNext(input logic [RPW-1:0] p);
    return (p == RPW'(RSP_DEPTH - 1)) ? '0 : p + RPW'(1);
  endfunction

  assign cmd_ready = (r_cmdCount < CW'(DEPTH));
  assign w_cmdPush = cmd_valid && cmd_ready;
  assign w_rspPop  = rsp_valid && rsp_ready;
  assign w_cmdHead = r_cmdMem[r_cmdRdPtr];

  // Credit: every command in S1, S2 or the response queue owns a slot; a pop
  // this cycle frees one. Compared as "inUse < RSP_DEPTH + pop" to avoid a
  // subtraction that could underflow.
  assign w_inUse = SW'(r_s1Valid) + SW'(r_s2Valid) + SW'(r_rspCount);
  assign w_issue = (r_cmdCount != '0) && (w_inUse < (SW'(RSP_DEPTH) + SW'(w_rspPop)));

  // Command FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_cmdPush) begin
      r_cmdMem[r_cmdWrPtr] <= {cmd_a, cmd_b, cmd_op, cmd_tag};
    end
  end

  // Command FIFO pointers and occupancy. DEPTH is a power of two, so the
  // pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmdWrPtr <= '0;
      r_cmdRdPtr <= '0;
      r_cmdCount <= '0;
    end else begin
      if (w_cmdPush) r_cmdWrPtr <= r_cmdWrPtr + PW'(1);
      if (w_issue)   r_cmdRdPtr <= r_cmdRdPtr + PW'(1);
      r_cmdCount <= r_cmdCount + CW'(w_cmdPush) - CW'(w_issue);
    end
  end

  // In-flight stages. S1 owns the ALU input registers, which hold their last
  // values on cycles without an issue. S2 shadows the ALU's own register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      r_s1Valid   <= 1'b0;
      r_s1Illegal <= 1'b0;
      r_s1Tag     <= '0;
      r_s2Valid   <= 1'b0;
      r_s2Illegal <= 1'b0;
      r_s2Tag     <= '0;
    end else begin
      r_s1Valid <= w_issue;
      if (w_issue) begin
        alu_a       <= w_cmdHead[CMD_W-1 -: 8];
        alu_b       <= w_cmdHead[CMD_W-9 -: 8];
        alu_opcode  <= w_cmdHead[TAG_W+2 : TAG_W];
        r_s1Tag     <= w_cmdHead[TAG_W-1:0];
        r_s1Illegal <= (w_cmdHead[TAG_W+2 : TAG_W] == 3'b111);
      end
      r_s2Valid   <= r_s1Valid;
      r_s2Tag     <= r_s1Tag;
      r_s2Illegal <= r_s1Illegal;
    end
  end

  // Response queue. Storage is reset so the head reads zero out of reset.
  // Capture and pop may coincide at any occupancy; the credit check
  // guarantees capture never sees a full queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RSP_DEPTH; i++) r_rspMem[i] <= '0;
      r_rspWrPtr <= '0;
      r_rspRdPtr <= '0;
      r_rspCount <= '0;
    end else begin
      if (r_s2Valid) begin
        r_rspMem[r_rspWrPtr] <= {r_s2Illegal, r_s2Tag, alu_result};
        r_rspWrPtr           <= rspNext(r_rspWrPtr);
      end
      if (w_rspPop) r_rspRdPtr <= rspNext(r_rspRdPtr);
      r_rspCount <= r_rspCount + RCW'(r_s2Valid) - RCW'(w_rspPop);
    end
  end

  assign rsp_valid                           = (r_rspCount != '0);
  assign {rsp_illegal, rsp_tag, rsp_result}  = r_rspMem[r_rspRdPtr];
  assign cmd_count                           = r_cmdCount;
  assign busy = (r_cmdCount != '0) || r_s1Valid || r_s2Valid || (r_rspCount != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer. Stands in for simple_alu with a registered
// behavioural ALU and checks every response against a queue of expected
// results built from the accepted commands.
module tb_alu_cmd_sequencer;

   localparam int DEPTH     = 4;
   localparam int RSP_DEPTH = 4;
   localparam int TAG_W     = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [7:0]       cmd_a = '0;
   logic [7:0]       cmd_b = '0;
   logic [2:0]       cmd_op = '0;
   logic [TAG_W-1:0] cmd_tag = '0;
   logic [7:0]       alu_a;
   logic [7:0]       alu_b;
   logic [2:0]       alu_opcode;
   logic [15:0]      alu_result = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [15:0]      rsp_result;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_illegal;
   logic [2:0]       cmd_count;
   logic             busy;

   typedef struct {
      logic [15:0]      res;
      logic [TAG_W-1:0] tag;
      logic             ill;
   } exp_t;

   exp_t       expQ[$];
   logic [7:0] accA[$];
   logic [7:0] accB[$];
   logic [2:0] accOp[$];

   int compared      = 0;
   int mismatched    = 0;
   int acceptedCount = 0;
   int maxOcc        = 0;

   logic [7:0] swA [6]  = '{8'h00, 8'hFF, 8'hF0, 8'h0F, 8'h12, 8'h80};
   logic [7:0] swB [6]  = '{8'h01, 8'hFF, 8'h3C, 8'h0F, 8'h34, 8'h80};
   logic [2:0] swOp [6] = '{3'd1,  3'd2,  3'd3,  3'd6,  3'd7,  3'd0};

   alu_cmd_sequencer #(.DEPTH(DEPTH), .RSP_DEPTH(RSP_DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
      .cmd_count(cmd_count), .busy(busy)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // ALU arithmetic as seen in a 16-bit result: ADD/SUB/MUL full width,
   // logic ops zero-extended, opcode 7 returns the illegal marker.
   function automatic logic [15:0] aluModel(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op);
      case (op)
         3'd0:    return 16'(a) + 16'(b);
         3'd1:    return 16'(a) - 16'(b);
         3'd2:    return 16'(a) * 16'(b);
         3'd3:    return {8'h00, a & b};
         3'd4:    return {8'h00, a | b};
         3'd5:    return {8'h00, a ^ b};
         3'd6:    return {8'h00, ~(a ^ b)};
         default: return 16'hDEAD;
      endcase
   endfunction

   // The simple_alu stand-in registers its result every edge, never stalls.
   always @(posedge clk) alu_result <= aluModel(alu_a, alu_b, alu_opcode);

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, compare the response
   // head against the model, then update the model from the handshakes that
   // completed at the rising edge. Returns 1 time unit after the rising edge.
   task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] op, input logic [TAG_W-1:0] tag,
                                input logic rr);
      logic acc;
      logic pop;
      int   occ;
      @(negedge clk);
      cmd_valid = v;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_tag   = tag;
      rsp_ready = rr;
      checkOutput("busy", busy, expQ.size() != 0);
      acc = cmd_valid && cmd_ready;
      pop = rsp_valid && rsp_ready;
      if (rsp_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("spuriousRsp", rsp_valid, 0);
         end else begin
            checkOutput("rspResult", rsp_result, expQ[0].res);
            checkOutput("rspTag", rsp_tag, expQ[0].tag);
            checkOutput("rspIllegal", rsp_illegal, expQ[0].ill);
         end
      end
      @(posedge clk);
      if (acc) begin
         expQ.push_back('{res: aluModel(a, b, op), tag: tag, ill: (op == 3'b111)});
         accA.push_back(a);
         accB.push_back(b);
         accOp.push_back(op);
         acceptedCount++;
      end
      if (pop && expQ.size() != 0) void'(expQ.pop_front());
      #1;
      occ = expQ.size() - int'(cmd_count);
      if (occ > maxOcc) maxOcc = occ;
   endtask

   task automatic idle(input logic rr);
      applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, '0, rr);
   endtask

   task automatic drainAll();
      int n = 0;
      while (expQ.size() != 0 && n < 200) begin
         idle(1'b1);
         n++;
      end
      checkOutput("drainDone", expQ.size(), 0);
   endtask

   initial begin
      // Reset values while reset is held
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstAluA", alu_a, 0);
      checkOutput("rstAluB", alu_b, 0);
      checkOutput("rstAluOp", alu_opcode, 0);
      checkOutput("rstRspValid", rsp_valid, 0);
      checkOutput("rstRspResult", rsp_result, 0);
      checkOutput("rstRspTag", rsp_tag, 0);
      checkOutput("rstRspIllegal", rsp_illegal, 0);
      checkOutput("rstCmdCount", cmd_count, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstCmdReady", cmd_ready, 1);
      @(negedge clk);
      rst = 1'b0;

      // Basic ADD: response visible exactly three edges after accept
      applyStimulus(1'b1, 8'hFF, 8'h01, 3'd0, 4'd3, 1'b1);
      checkOutput("latE0", rsp_valid, 0);
      idle(1'b1);
      checkOutput("latE1", rsp_valid, 0);
      checkOutput("issueA", alu_a, 8'hFF);
      checkOutput("issueB", alu_b, 8'h01);
      checkOutput("issueOp", alu_opcode, 3'd0);
      idle(1'b1);
      checkOutput("latE2", rsp_valid, 0);
      idle(1'b1);
      checkOutput("latE3", rsp_valid, 1);
      checkOutput("addResult", rsp_result, 16'h0100);
      checkOutput("addTag", rsp_tag, 4'd3);
      checkOutput("addIllegal", rsp_illegal, 0);
      idle(1'b1);
      idle(1'b1);
      // Empty-FIFO corner: ALU inputs hold their last issued values
      checkOutput("holdA", alu_a, 8'hFF);
      checkOutput("holdB", alu_b, 8'h01);
      checkOutput("holdOp", alu_opcode, 3'd0);
      checkOutput("idleBusy", busy, 0);

      // Opcode sweep, back to back: one response per cycle, in order
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, swA[i], swB[i], swOp[i], 4'(i + 1), 1'b1);
         checkOutput("sweepValid", rsp_valid, (i >= 3));
      end
      for (int j = 0; j < 4; j++) begin
         idle(1'b1);
         checkOutput("sweepValid", rsp_valid, (j < 3));
      end
      drainAll();

      // Backpressure: consumer stalled, offer ten commands
      acceptedCount = 0;
      accA.delete();
      accB.delete();
      accOp.delete();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 4'(i), 1'b0);
      end
      checkOutput("bpAccepted", acceptedCount, DEPTH + RSP_DEPTH);
      checkOutput("bpCmdCount", cmd_count, DEPTH);
      checkOutput("bpCmdReady", cmd_ready, 0);
      checkOutput("bpRspValid", rsp_valid, 1);
      checkOutput("bpAluA", alu_a, accA[RSP_DEPTH-1]);
      repeat (3) idle(1'b0);
      checkOutput("bpHoldA", alu_a, accA[RSP_DEPTH-1]);
      checkOutput("bpHoldB", alu_b, accB[RSP_DEPTH-1]);
      checkOutput("bpHoldOp", alu_opcode, accOp[RSP_DEPTH-1]);
      drainAll();

      // Random consumer readiness with continuous commands
      maxOcc = 0;
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      drainAll();
      checkOutput("occBound", (maxOcc <= RSP_DEPTH), 1);

      // Reset in the middle of traffic
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 4'(i), 1'b0);
      end
      #2 rst = 1'b1;
      #1;
      checkOutput("midRstRspValid", rsp_valid, 0);
      checkOutput("midRstRspResult", rsp_result, 0);
      checkOutput("midRstRspTag", rsp_tag, 0);
      checkOutput("midRstCmdCount", cmd_count, 0);
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstAluA", alu_a, 0);
      checkOutput("midRstCmdReady", cmd_ready, 1);
      expQ.delete();
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         idle(1'b1);
         checkOutput("postRstQuiet", rsp_valid, 0);
      end
      applyStimulus(1'b1, 8'h05, 8'h03, 3'd1, 4'd9, 1'b1);
      drainAll();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
